// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and sizing helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  // Pointer width for a FIFO of the given depth; never narrower than one bit.
  function automatic int unsigned FQ_AW(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must hold 0..maxOs inclusive.
  function automatic int unsigned OS_W(input int unsigned maxOs);
    return $clog2(maxOs + 1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: memory request/response bus, decode handshake and control inputs of the fetch stage.
interface fetch_if #(parameter int unsigned XLEN = 32);

  logic            fetch_hold;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;

  modport master (
    input  fetch_hold, redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_inst, if_pc
  );

  modport slave (
    output fetch_hold, redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_inst, if_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO with flush and a registered head word.
// The head register keeps its last value while the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = FQ_AW(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             doPush, doPop;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = head_q;
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);

  // Next pointers, occupancy and head word; flush wins over push and pop.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    head_d  = head_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = nextPtr(wrPtr_q);
      if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
      count_d = count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
      if (doPop) begin
        if (count_q > (AW+1)'(1)) head_d = mem_q[nextPtr(rdPtr_q)];
        else if (doPush)          head_d = data_i;
      end else if (empty_o && doPush) begin
        head_d = data_i;
      end
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Storage array; contents only matter once written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generator, in-order pipelined IMEM interface, fetch queue and
// valid/ready handoff to decode, with redirect flush and hold support.
// Optional macro FETCH_PERF_EN adds perf_fetched/perf_starve/perf_flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     FQ_DEPTH        = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_starve,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned QW = FQ_AW(FQ_DEPTH);
  localparam int unsigned TW = FQ_AW(MAX_OUTSTANDING);
  localparam int unsigned DW = OS_W(MAX_OUTSTANDING);

  logic [XLEN-1:0]   fetchPc_q, fetchPc_d;
  logic [DW-1:0]     dropCnt_q, dropCnt_d;
  logic [QW:0]       fqCount;
  logic              fqFull, fqEmpty;
  logic [TW:0]       osCount;
  logic              tagFull, tagEmpty;
  logic [XLEN-1:0]   tagPc;
  logic [2*XLEN-1:0] fqHead;
  logic              credit, accept, respond, dropResp, pushEntry, popEntry;

  // A slot exists only if the queue can absorb every response already in flight.
  assign credit    = !fqFull && !tagFull && ((32'(fqCount) + 32'(osCount)) < 32'(FQ_DEPTH));
  assign accept    = bus.imem_req & bus.imem_gnt;
  assign respond   = bus.imem_rvalid & ~tagEmpty;
  assign dropResp  = respond & (bus.redirect_valid | (dropCnt_q != '0));
  assign pushEntry = respond & ~dropResp;
  assign popEntry  = ~fqEmpty & bus.if_ready & ~bus.redirect_valid;

  assign bus.imem_req  = rst_n & credit & ~bus.fetch_hold & ~bus.redirect_valid;
  assign bus.imem_addr = fetchPc_q;
  assign bus.if_valid  = ~fqEmpty;
  assign bus.if_pc     = fqHead[2*XLEN-1:XLEN];
  assign bus.if_inst   = fqHead[XLEN-1:0];

  // PC tags of granted requests; its occupancy is the outstanding count.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .data_i  (fetchPc_q),
    .pop_i   (respond),
    .flush_i (1'b0),
    .data_o  (tagPc),
    .full_o  (tagFull),
    .empty_o (tagEmpty),
    .count_o (osCount)
  );

  // Fetch queue of {pc, inst} pairs presented to decode.
  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FQ_DEPTH)) u_fetch_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pushEntry),
    .data_i  ({tagPc, bus.imem_rdata}),
    .pop_i   (popEntry),
    .flush_i (bus.redirect_valid),
    .data_o  (fqHead),
    .full_o  (fqFull),
    .empty_o (fqEmpty),
    .count_o (fqCount)
  );

  // Redirect retargets the PC and marks every still-unanswered request as stale.
  always_comb begin
    fetchPc_d = fetchPc_q;
    dropCnt_d = dropCnt_q;
    if (bus.redirect_valid) begin
      fetchPc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      dropCnt_d = DW'(32'(osCount) + 32'(accept) - 32'(respond));
    end else begin
      if (accept) fetchPc_d = fetchPc_q + XLEN'(4);
      if (respond && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - DW'(1);
    end
  end

  // PC and stale-response counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc_q <= RESET_PC;
      dropCnt_q <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  // A response with nothing outstanding is a memory-side bug; hardware ignores it.
  assert property (@(posedge clk) disable iff (!rst_n) !(bus.imem_rvalid && tagEmpty));

`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched_q, perfStarve_q, perfFlushed_q;

  // Delivered instructions, decode-starved cycles, and work thrown away by redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfFetched_q <= '0;
      perfStarve_q  <= '0;
      perfFlushed_q <= '0;
    end else begin
      if (popEntry) perfFetched_q <= perfFetched_q + 32'd1;
      if (bus.if_ready && fqEmpty && !bus.redirect_valid) perfStarve_q <= perfStarve_q + 32'd1;
      perfFlushed_q <= perfFlushed_q + (bus.redirect_valid ? 32'(fqCount) : 32'd0) + 32'(dropResp);
    end
  end

  assign perf_fetched = perfFetched_q;
  assign perf_starve  = perfStarve_q;
  assign perf_flushed = perfFlushed_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a queue-based reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned FQ_DEPTH = 4;
  localparam int unsigned MAX_OS   = 2;
  localparam logic [31:0] RST_PC   = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n;

  fetch_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_starve, perf_flushed;
`endif

  fetch_unit #(
    .XLEN(XLEN), .FQ_DEPTH(FQ_DEPTH), .MAX_OUTSTANDING(MAX_OS), .RESET_PC(RST_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_starve  (perf_starve),
    .perf_flushed (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int gntRate = 100;
  int rspRate = 100;

  logic [31:0] pending[$];
  fq_entry_t   mq[$];
  int          dropN = 0;
  logic [31:0] expReqPc;
  logic [31:0] expDelPc;
  int grants = 0, pops = 0, drops = 0, starves = 0, cleared = 0;
  int firstGnt = -1, firstValid = -1;
  logic [31:0] gntLog[$];
  logic [31:0] firstPopPc = '0;
  bit          awaitFirstPop = 1'b0;
  int g0, d0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare DUT outputs with the model just before the edge, then advance the model.
  task automatic observeCycle(input logic rdy, input logic hold, input logic rv, input logic [31:0] rpc);
    logic      expReq, acc, popNow, newValid;
    fq_entry_t ne;
    logic [31:0] a;
    expReq = ((mq.size() + pending.size()) < FQ_DEPTH) && (pending.size() < MAX_OS) && !hold && !rv;
    checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq));
    if (bus.imem_req) checkOutput("imem_addr", bus.imem_addr, expReqPc);
    checkOutput("if_valid", 32'(bus.if_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      checkOutput("if_pc", bus.if_pc, mq[0].pc);
      checkOutput("if_inst", bus.if_inst, mq[0].inst);
    end
    if (bus.if_valid === 1'b1 && firstValid < 0) firstValid = cycle;
    acc    = bus.imem_req && bus.imem_gnt;
    popNow = (mq.size() > 0) && rdy && !rv;
    if (popNow) begin
      checkOutput("stream_pc", bus.if_pc, expDelPc);
      expDelPc = expDelPc + 32'd4;
      pops++;
      if (awaitFirstPop) begin
        firstPopPc    = bus.if_pc;
        awaitFirstPop = 1'b0;
      end
    end
    if (rdy && mq.size() == 0 && !rv) starves++;
    if (acc) begin
      if (firstGnt < 0) firstGnt = cycle;
      gntLog.push_back(bus.imem_addr);
      grants++;
    end
    newValid = 1'b0;
    if (bus.imem_rvalid) begin
      a = pending.pop_front();
      if (rv || dropN > 0) begin
        drops++;
        if (!rv) dropN--;
      end else begin
        newValid = 1'b1;
        ne.pc    = a;
        ne.inst  = memWord(a);
      end
    end
    if (acc) begin
      pending.push_back(expReqPc);
      expReqPc = expReqPc + 32'd4;
    end
    if (rv) begin
      cleared += mq.size();
      mq.delete();
      dropN         = pending.size();
      expReqPc      = rpc & 32'hFFFF_FFFC;
      expDelPc      = rpc & 32'hFFFF_FFFC;
      awaitFirstPop = 1'b1;
    end else begin
      if (popNow) void'(mq.pop_front());
      if (newValid) mq.push_back(ne);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check before the rising edge.
  task automatic applyStimulus(input logic rdy, input logic hold, input logic rv, input logic [31:0] rpc);
    bus.if_ready       = rdy;
    bus.fetch_hold     = hold;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_gnt       = (int'($urandom_range(99)) < gntRate);
    if (pending.size() > 0 && int'($urandom_range(99)) < rspRate) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memWord(pending[0]);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = NOP_INST;
    end
    #4;
    observeCycle(rdy, hold, rv, rpc);
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.if_ready       = 1'b0;
    bus.fetch_hold     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    expReqPc           = RST_PC;
    expDelPc           = RST_PC;

    repeat (2) @(negedge clk);
    #4;
    checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("rst_if_inst", bus.if_inst, 32'd0);
    checkOutput("rst_if_pc", bus.if_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] streaming from reset PC");
    gntRate = 100;
    rspRate = 100;
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("first_latency", 32'(firstValid - firstGnt), 32'd2);
    checkOutput("addr_seq0", gntLog[0], 32'h100);
    checkOutput("addr_seq1", gntLog[1], 32'h104);
    checkOutput("addr_seq2", gntLog[2], 32'h108);

    $display("[TB] decode stalled until the queue fills");
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("full_no_req", 32'(bus.imem_req), 32'd0);
    checkOutput("no_loss", 32'(grants - pops - drops), 32'(FQ_DEPTH));
    for (int p = 0; p < 3; p++) begin
      g0 = grants;
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("pulse_refill", 32'(grants - g0), 32'd1);
    end

    $display("[TB] redirect with two requests outstanding");
    rspRate = 0;
    for (int i = 0; i < 20 && pending.size() != MAX_OS; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("two_outstanding", 32'(pending.size()), 32'(MAX_OS));
    d0 = drops;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200);
    checkOutput("flush_empty", 32'(bus.if_valid), 32'd0);
    rspRate = 100;
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("drop_two", 32'(drops - d0), 32'd2);
    checkOutput("first_after_redirect", firstPopPc, 32'h200);

    $display("[TB] unaligned and back-to-back redirects");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h203);
    checkOutput("masked_addr", bus.imem_addr, 32'h200);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h300);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h400);
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("last_redirect_wins", firstPopPc, 32'h400);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF4);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("pc_wrap", firstPopPc, 32'hFFFF_FFF4);

    $display("[TB] hold mid-stream");
    g0 = grants;
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("hold_no_grant", 32'(grants - g0), 32'd0);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, '0);

    $display("[TB] randomized traffic");
    gntRate = 60;
    rspRate = 60;
    repeat (400) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 20) == 0, $urandom);
    end

`ifdef FETCH_PERF_EN
    checkOutput("perf_fetched", perf_fetched, 32'(pops));
    checkOutput("perf_starve", perf_starve, 32'(starves));
    checkOutput("perf_flushed", perf_flushed, 32'(cleared + drops));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
